// File: rtl/uart_pkg.sv
// Shared types, limits and helpers for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_MAX     = 8;
    localparam int DATA_MIN     = 5;
    localparam int BIT_PERIOD_W = 14;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    function automatic logic [3:0] size_eff(input logic [3:0] s);
        if (s < 4'(DATA_MIN)) return 4'(DATA_MIN);
        if (s > 4'(DATA_MAX)) return 4'(DATA_MAX);
        return s;
    endfunction

    function automatic logic [BIT_PERIOD_W-1:0] period_eff(
        input logic [BIT_PERIOD_W-1:0] p
    );
        return (p == '0) ? BIT_PERIOD_W'(1) : p;
    endfunction

    function automatic logic [7:0] data_mask(input logic [3:0] n);
        return 8'hFF >> (4'd8 - n);
    endfunction

endpackage

// File: rtl/uart_transmitter_flex_counter.sv
// Wrapping up-counter: counts 0..rollover_val then returns to 0.
// clear has priority over count_enable.
module flex_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         count_enable,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val)
                count_out <= '0;
            else
                count_out <= count_out + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 5..8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to add an even-parity bit before stop.
module uart_transmitter
    import uart_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_start,
    input  logic [7:0]              tx_data,
    input  logic [BIT_PERIOD_W-1:0] bit_period,
    input  logic [3:0]              data_size,
    output logic                    tx_out,
    output logic                    tx_busy,
    output logic                    tx_done
);

    state_t                  state_q;
    state_t                  state_d;
    logic [7:0]              data_q;
    logic [BIT_PERIOD_W-1:0] period_q;
    logic [3:0]              size_q;
    logic                    done_q;
    logic [BIT_PERIOD_W-1:0] tick_cnt;
    logic [3:0]              bit_idx;
    logic                    load;
    logic                    bit_tick;
    logic                    last_bit;
    logic                    tx_d;

    assign load     = (state_q == IDLE) && tx_start;
    assign tx_busy  = (state_q != IDLE);
    assign bit_tick = tx_busy &&
                      (tick_cnt == period_q - 1'b1);
    assign last_bit = (bit_idx == size_q - 4'd1);
    assign tx_done  = done_q;
    assign tx_out   = tx_d;

    flex_counter #(.W(BIT_PERIOD_W)) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (load),
        .count_enable (tx_busy),
        .rollover_val (period_q - 1'b1),
        .count_out    (tick_cnt)
    );

    flex_counter #(.W(4)) u_bit_index (
        .clk          (clk),
        .rst          (rst),
        .clear        (load),
        .count_enable ((state_q == DATA) && bit_tick),
        .rollover_val (size_q - 4'd1),
        .count_out    (bit_idx)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_q <= 1'b0;
        else if (load)
            parity_q <= ^(tx_data &
                          data_mask(size_eff(data_size)));
    end
`endif

    // data_q shifts right so the next bit is always at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            period_q <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == STOP) && bit_tick;
            if (load) begin
                data_q   <= tx_data;
                period_q <= period_eff(bit_period);
                size_q   <= size_eff(data_size);
            end else if ((state_q == DATA) && bit_tick) begin
                data_q <= data_q >> 1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (tx_start) state_d = START;
            end
            START: begin
                tx_d = 1'b0;
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                tx_d = data_q[0];
`ifdef UART_TX_PARITY_EN
                if (bit_tick && last_bit) state_d = PARITY;
`else
                if (bit_tick && last_bit) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter against a bit-list model.
// Honours UART_TX_PARITY_EN when compiled with it.
module tb_uart_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = '0;
    logic [13:0] bit_period = '0;
    logic [3:0]  data_size = '0;
    logic        tx_out;
    logic        tx_busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    uart_transmitter dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .bit_period (bit_period),
        .data_size  (data_size),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Expected line: start 0, n data bits LSB first, [parity], stop 1,
    // each held pe cycles, then one tx_done cycle.
    task automatic run_frame(input logic [7:0]  d,
                             input logic [13:0] bp,
                             input logic [3:0]  sz,
                             input bit          hold,
                             input bit          scram,
                             input string       tag);
        bit q[$];
        bit par;
        int n, pe, len;
        pe  = (bp == 0) ? 1 : int'(bp);
        n   = (sz < 5) ? 5 : ((sz > 8) ? 8 : int'(sz));
        par = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            par ^= d[i];
        end
`ifdef UART_TX_PARITY_EN
        q.push_back(par);
`endif
        q.push_back(1'b1);
        len = q.size() * pe;
        tx_data    = d;
        bit_period = bp;
        data_size  = sz;
        tx_start   = 1'b1;
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
        for (int c = 0; c < len; c++) begin
            check({tag, ":out"}, 32'(tx_out), 32'(q[c / pe]));
            check({tag, ":busy"}, 32'(tx_busy), 32'd1);
            check({tag, ":done_early"}, 32'(tx_done), 32'd0);
            if (scram) begin
                tx_data    = 8'($urandom);
                bit_period = 14'($urandom_range(0, 20));
                data_size  = 4'($urandom);
                tx_start   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        check({tag, ":done"}, 32'(tx_done), 32'd1);
        check({tag, ":idle_busy"}, 32'(tx_busy), 32'd0);
        check({tag, ":idle_out"}, 32'(tx_out), 32'd1);
        tx_start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;

        run_frame(8'hA5, 14'd10, 4'd8, 1'b0, 1'b0, "a5_bp10");
        @(negedge clk);
        check("idle_gap_done", 32'(tx_done), 32'd0);
        run_frame(8'hFF, 14'd3, 4'd3, 1'b0, 1'b0, "size3");
        run_frame(8'hFF, 14'd3, 4'd12, 1'b0, 1'b0, "size12");
        run_frame(8'h15, 14'd0, 4'd5, 1'b0, 1'b0, "bp0");

        for (int f = 0; f < 3; f++)
            run_frame(8'($urandom), 14'd4, 4'd8, 1'b1, 1'b0, "b2b");

        run_frame(8'h3C, 14'd6, 4'd7, 1'b0, 1'b1, "scramble");
        @(negedge clk);
        check("no_queue_busy", 32'(tx_busy), 32'd0);

        // abort during the third data bit (cycles 15..19 of bp=5)
        tx_data    = 8'hC3;
        bit_period = 14'd5;
        data_size  = 4'd8;
        tx_start   = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_abort_bit2", 32'(tx_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_out", 32'(tx_out), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_done", 32'(tx_done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_hold_done", 32'(tx_done), 32'd0);
        end
        rst = 1'b0;
        run_frame(8'h5A, 14'd2, 4'd6, 1'b0, 1'b0, "post_rst");

        for (int f = 0; f < 25; f++)
            run_frame(8'($urandom), 14'($urandom_range(0, 6)),
                      4'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "rand");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port tx_start, input, 1 bit: request to send the frame in tx_data.
REQ-004 SHALL have port tx_data, input, 8 bits: payload, transmitted LSB first.
REQ-005 SHALL have port bit_period, input, 14 bits: clocks per serial bit.
REQ-006 SHALL have port data_size, input, 4 bits: payload bits per frame.
REQ-007 SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port tx_busy, output, 1 bit: high while a frame is in flight.
REQ-009 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only with REQ-026) and STOP.
REQ-011 In IDLE, tx_start=1 at a clock edge SHALL latch tx_data, bit_period and data_size and move to START; tx_out goes low on the next cycle.
REQ-012 Each serial bit (start, data, parity, stop) SHALL hold tx_out constant for exactly bit_period cycles.
REQ-013 A bit_period of 0 SHALL be treated as 1.
REQ-014 Data bits SHALL be sent LSB first, tx_data[0] first.
REQ-015 Exactly data_size data bits SHALL be sent; data_size<5 SHALL be treated as 5 and data_size>8 as 8.
REQ-016 The stop bit SHALL be a single high bit.
REQ-017 Transitions: START->DATA after one bit; DATA->PARITY (or STOP) after the last data bit; PARITY->STOP after one bit; STOP->IDLE after one bit.
REQ-018 tx_busy SHALL be high in every state except IDLE.
REQ-019 tx_done SHALL pulse high for exactly one cycle, the first IDLE cycle after STOP.
REQ-020 tx_start in the tx_done cycle SHALL be accepted, allowing back-to-back frames with no extra idle bit.
REQ-021 tx_start while tx_busy=1 SHALL be ignored; changes to tx_data, bit_period and data_size mid-frame SHALL have no effect.
REQ-022 Frame length SHALL be (data_size_eff + 2 [+1 parity]) * bit_period_eff cycles from the first low cycle to the tx_done cycle.

Reset
REQ-023 While rst=1: state SHALL be IDLE, tx_out=1, tx_busy=0, tx_done=0, and all counters and latched registers SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; tx_out returns high asynchronously and no tx_done is produced.
REQ-025 After rst deasserts, the first tx_start SHALL be accepted on the first clock edge.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the data_size_eff data bits) SHALL be inserted between the last data bit and the stop bit.
REQ-027 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and frames SHALL be start + data + stop.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum, DATA_MAX=8, DATA_MIN=5 and BIT_PERIOD_W=14.
REQ-029 Bit timing SHALL use one sub-module instance, flex_counter (14-bit); the bit index SHALL use a second flex_counter instance (4-bit) or a local counter.

Verification
REQ-030 Scenario: bit_period=10, data_size=8, tx_data=8'hA5, pulse tx_start -> tx_out shows 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done pulses at cycle 100 (110 with parity, parity bit=0).
REQ-031 Scenario: data_size=3 and data_size=12 with tx_data=8'hFF -> 5 and 8 data bits respectively, verified by bit count on tx_out.
REQ-032 Scenario: tx_start held high continuously, bit_period=4 -> back-to-back frames, start bit immediately follows stop bit, one tx_done per frame.
REQ-033 Scenario: tx_start and tx_data changed mid-frame -> frame unchanged, no second frame queued.
REQ-034 Scenario: rst asserted during the third data bit -> tx_out=1, tx_busy=0 at once, no tx_done; a new tx_start after release gives a clean frame.
REQ-035 Scenario: bit_period=0, data_size=5, tx_data=8'h15 -> each bit lasts 1 cycle, frame 7 cycles (8 with parity, parity bit=1).
